// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC control path. Owns the PC register, drives the next-PC
// mux select and load strobe, and sequences fetch/decode/exec/update with sticky faults.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        MemReady,
    input  logic        IsBranch,
    input  logic        IsJump,
    input  logic        Zero,
    input  logic [31:0] NextPC,
    output logic [1:0]  PCSel,
    output logic        PCWrite,
    output logic        FetchReq,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Fault,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    // Counter value on the last FETCH cycle allowed before the timeout fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  pcsel_q, pcsel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pc_write, fetch_req;

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values of its peers; reset is synchronous, so it lives inside the edge branch.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pcsel_q <= SEL_PC4;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcsel_q <= pcsel_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcsel_d   = pcsel_q;
        cnt_d     = cnt_q;
        pc_write  = 1'b0;
        fetch_req = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!Stall) state_d = S_FETCH;
            end

            S_FETCH: begin
                fetch_req = 1'b1;
                if (!Stall) begin
                    // A ready word wins over a timeout reached on the same cycle.
                    if (MemReady) begin
                        state_d = S_DECODE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_DECODE: begin
                if (!Stall) state_d = S_EXEC;
            end

            S_EXEC: begin
                if (!Stall) begin
                    if (IsJump)                pcsel_d = SEL_JUMP;
                    else if (IsBranch && Zero) pcsel_d = SEL_BRANCH;
                    else                       pcsel_d = SEL_PC4;
                    state_d = S_UPDATE;
                end
            end

            S_UPDATE: begin
                if (!Stall) begin
                    // A misaligned target never reaches the PC register.
                    if (NextPC[1:0] == 2'b00) begin
                        pc_write = 1'b1;
                        pc_d     = NextPC;
                        cnt_d    = 8'd0;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign PCSel    = pcsel_q;
    assign PCWrite  = pc_write;
    assign FetchReq = fetch_req;
    assign PC       = pc_q;
    assign PCPlus4  = pc_q + 32'd4;
    assign Fault    = (state_q == S_FAULT);
    assign State    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed and randomized instructions checked
// against an instruction-level model of the PC (next PC computed from the decode rules).
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TMO    = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        MemReady = 1'b0;
    logic        IsBranch = 1'b0;
    logic        IsJump = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] NextPC;
    logic [1:0]  PCSel;
    logic        PCWrite;
    logic        FetchReq;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Fault;
    logic [2:0]  State;

    logic [31:0] br_tgt = 32'h0;
    logic [31:0] jmp_tgt = 32'h0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [1:0]  exp_sel = 2'b00;
    bit          faulted = 1'b0;

    // Environment: the next-PC mux that the sequencer steers.
    assign NextPC = (PCSel == 2'b10) ? jmp_tgt :
                    (PCSel == 2'b01) ? br_tgt  : PCPlus4;

    pc_sequencer #(
        .RESET_PC     (RST_PC),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Stall   (Stall),
        .MemReady(MemReady),
        .IsBranch(IsBranch),
        .IsJump  (IsJump),
        .Zero    (Zero),
        .NextPC  (NextPC),
        .PCSel   (PCSel),
        .PCWrite (PCWrite),
        .FetchReq(FetchReq),
        .PC      (PC),
        .PCPlus4 (PCPlus4),
        .Fault   (Fault),
        .State   (State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, landing on the falling edge.
    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic junk();
        IsJump   = 1'($urandom_range(1));
        IsBranch = 1'($urandom_range(1));
        Zero     = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        Stall = 1'b0;
        MemReady = 1'b0;
        cyc();
        check("rst_state", 32'(State), 0);
        check("rst_pc", PC, RST_PC);
        check("rst_pcsel", 32'(PCSel), 0);
        check("rst_fault", 32'(Fault), 0);
        check("rst_fetchreq", 32'(FetchReq), 0);
        check("rst_pcwrite", 32'(PCWrite), 0);
        Rst = 1'b1;
        cyc();
        check("first_fetch_state", 32'(State), 1);
        check("first_fetchreq", 32'(FetchReq), 1);
        exp_pc  = RST_PC;
        exp_sel = 2'b00;
        faulted = 1'b0;
    endtask

    // Called in FETCH; wait_n empty cycles and stall_n stalled cycles in random order,
    // then MemReady. Returns on the first DECODE cycle.
    task automatic do_fetch(input int wait_n, input int stall_n);
        int rem_w;
        int rem_s;
        rem_w = wait_n;
        rem_s = stall_n;
        while (rem_w + rem_s > 0) begin
            if (rem_s > 0 && (rem_w == 0 || $urandom_range(1) == 1)) begin
                Stall = 1'b1;
                MemReady = 1'($urandom_range(1));
                rem_s--;
            end else begin
                Stall = 1'b0;
                MemReady = 1'b0;
                rem_w--;
            end
            #1;
            check("fetch_state", 32'(State), 1);
            check("fetch_req", 32'(FetchReq), 1);
            check("fetch_pcwrite", 32'(PCWrite), 0);
            cyc();
        end
        Stall = 1'b0;
        MemReady = 1'b1;
        check("fetch_last_state", 32'(State), 1);
        cyc();
        MemReady = 1'($urandom_range(1));
        check("decode_state", 32'(State), 2);
        check("decode_fetchreq", 32'(FetchReq), 0);
    endtask

    task automatic run_instr(input bit isj, input bit isb, input bit z,
                             input logic [31:0] btgt, input logic [31:0] jtgt,
                             input int wait_n, input int stall_n,
                             input int xstall, input int ustall);
        logic [31:0] nxt;
        bit          aligned;
        do_fetch(wait_n, stall_n);
        junk();
        cyc();
        repeat (xstall) begin
            Stall = 1'b1;
            junk();
            cyc();
            check("exec_stall_state", 32'(State), 3);
        end
        Stall = 1'b0;
        check("exec_state", 32'(State), 3);
        check("exec_pcsel_hold", 32'(PCSel), 32'(exp_sel));
        IsJump = isj;
        IsBranch = isb;
        Zero = z;
        br_tgt = btgt;
        jmp_tgt = jtgt;
        exp_sel = isj ? 2'b10 : (isb && z) ? 2'b01 : 2'b00;
        nxt = isj ? jtgt : (isb && z) ? btgt : exp_pc + 32'd4;
        aligned = (nxt[1:0] == 2'b00);
        cyc();
        junk();
        check("update_state", 32'(State), 4);
        check("update_pcsel", 32'(PCSel), 32'(exp_sel));
        repeat (ustall) begin
            Stall = 1'b1;
            #1;
            check("update_stall_pcwrite", 32'(PCWrite), 0);
            check("update_stall_pc", PC, exp_pc);
            cyc();
            check("update_stall_state", 32'(State), 4);
        end
        Stall = 1'b0;
        #1;
        check("update_pcwrite", 32'(PCWrite), 32'(aligned));
        check("pcplus4", PCPlus4, exp_pc + 32'd4);
        cyc();
        if (aligned) begin
            exp_pc = nxt;
            check("next_fetch_state", 32'(State), 1);
            check("new_pc", PC, exp_pc);
            check("new_pcwrite", 32'(PCWrite), 0);
        end else begin
            faulted = 1'b1;
            check("misalign_state", 32'(State), 5);
            check("misalign_fault", 32'(Fault), 1);
            check("misalign_pc", PC, exp_pc);
            check("misalign_fetchreq", 32'(FetchReq), 0);
            check("misalign_pcsel", 32'(PCSel), 32'(exp_sel));
        end
    endtask

    // Called in FETCH with the counter clear; MemReady never arrives.
    task automatic run_timeout(input int stall_n);
        int rem_w;
        int rem_s;
        rem_w = TMO;
        rem_s = stall_n;
        while (rem_w + rem_s > 0) begin
            check("tmo_wait_state", 32'(State), 1);
            if (rem_s > 0 && (rem_w <= 1 || $urandom_range(1) == 1)) begin
                Stall = 1'b1;
                MemReady = 1'($urandom_range(1));
                rem_s--;
            end else begin
                Stall = 1'b0;
                MemReady = 1'b0;
                rem_w--;
            end
            cyc();
        end
        Stall = 1'b0;
        MemReady = 1'b0;
        check("tmo_state", 32'(State), 5);
        check("tmo_fault", 32'(Fault), 1);
        check("tmo_fetchreq", 32'(FetchReq), 0);
        repeat (3) begin
            Stall = 1'($urandom_range(1));
            MemReady = 1'($urandom_range(1));
            junk();
            cyc();
            check("fault_hold_state", 32'(State), 5);
            check("fault_hold_pc", PC, exp_pc);
            check("fault_hold_pcwrite", 32'(PCWrite), 0);
            check("fault_hold_fault", 32'(Fault), 1);
        end
    endtask

    initial begin
        do_reset();

        // Plain sequential flow: 0x100 -> 0x104 -> 0x108 -> 0x10C.
        repeat (3) run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);

        run_instr(1'b0, 1'b1, 1'b1, 32'h200, 32'h0,   0, 0, 0, 0);
        run_instr(1'b0, 1'b1, 1'b0, 32'h300, 32'h0,   0, 0, 0, 0);
        run_instr(1'b1, 1'b1, 1'b1, 32'h600, 32'h400, 0, 0, 0, 0);

        // MemReady on the timeout cycle, then a stall mix with a 5-cycle UPDATE stall.
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, TMO - 1, 0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 2, 1, 5);

        // PC wrap through the top of the address space.
        run_instr(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        check("wrap_pc_zero", PC, 32'h0);

        run_timeout(0);
        do_reset();
        run_timeout(3);
        do_reset();

        run_instr(1'b1, 1'b0, 1'b0, 32'h0, 32'h302, 0, 0, 0, 0);
        do_reset();

        // Reset while in DECODE with a non-zero PC and jump select.
        run_instr(1'b1, 1'b0, 1'b0, 32'h0, 32'h500, 0, 0, 0, 0);
        do_fetch(0, 0);
        do_reset();

        // Reset mid-fetch must clear the timeout counter.
        Stall = 1'b0;
        MemReady = 1'b0;
        repeat (10) cyc();
        do_reset();
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, TMO - 1, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            bit          isj;
            bit          isb;
            bit          z;
            logic [31:0] bt;
            logic [31:0] jt;
            isj = ($urandom_range(3) == 0);
            isb = ($urandom_range(1) == 1);
            z   = ($urandom_range(1) == 1);
            bt  = $urandom & 32'hFFFF_FFFC;
            jt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) bt[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(7) == 0) jt[1:0] = 2'($urandom_range(3, 1));
            run_instr(isj, isb, z, bt, jt, int'($urandom_range(TMO - 1)),
                      int'($urandom_range(3)), int'($urandom_range(1)),
                      int'($urandom_range(2)));
            if (faulted) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
